trigger_array: RTL and testbench

Multi-channel successor to the single-channel trigger aligner: `NUM_CH` independent channels each turn a global rising trigger edge into one output pulse. The pulse starts a programmable number of clock cycles after the next BSYNC event and lasts a programmable number of cycles. The block sits between the register map (enables, phases, widths) and the per-channel trigger outputs, in the BSYNC clock domain.

---
 rtl/trigger_array_pkg.sv | 20 ++
 rtl/trigger_array_channel.sv | 134 +++++++++++++
 rtl/trigger_array.sv | 65 ++++++
 tb/tb_trigger_array.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/trigger_array_pkg.sv
// Shared types and constants for the multi-channel trigger aligner.
package trigger_array_pkg;

   localparam int STATE_W  = 3;
   localparam int MISSED_W = 8;

   typedef enum logic [STATE_W-1:0] {
      IDLE  = 3'd0,
      ARMED = 3'd1,
      LOAD  = 3'd2,
      DELAY = 3'd3,
      PULSE = 3'd4
   } trig_state_t;

   // Counter must span both the longest delay and the longest pulse.
   function automatic int cnt_width(input int phase_w, input int width_w);
      return (phase_w > width_w) ? phase_w : width_w;
   endfunction

endpackage

// File: rtl/trigger_array_channel.sv
// One trigger channel: waits for BSYNC after an edge, delays, then pulses.
// Optional missed-edge counter under TRIGGER_ARRAY_MISSED_CNT_EN.
module trigger_array_channel
   import trigger_array_pkg::*;
#(
   parameter int PHASE_W = 16,
   parameter int WIDTH_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               trig_edge,
   input  logic               bsync_event,
   input  logic               bsync_ready,
   input  logic               en,
   input  logic [PHASE_W-1:0] phase,
   input  logic [WIDTH_W-1:0] width,
   output logic [STATE_W-1:0] state,
`ifdef TRIGGER_ARRAY_MISSED_CNT_EN
   output logic               trig_out,
   output logic [MISSED_W-1:0] missed
`else
   output logic               trig_out
`endif
);

   localparam int CNT_W = cnt_width(PHASE_W, WIDTH_W);

   trig_state_t        state_reg, state_next;
   logic [PHASE_W-1:0] phase_reg, phase_next;
   logic [WIDTH_W-1:0] width_reg, width_next;
   logic [CNT_W-1:0]   cnt_reg, cnt_next;
   logic               pending_reg, pending_next;
   logic               active;
   logic [WIDTH_W-1:0] width_last;

   assign active     = en & bsync_ready;
   assign width_last = (width_reg == '0) ? '0 : width_reg - WIDTH_W'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg   <= IDLE;
         phase_reg   <= '0;
         width_reg   <= '0;
         cnt_reg     <= '0;
         pending_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         phase_reg   <= phase_next;
         width_reg   <= width_next;
         cnt_reg     <= cnt_next;
         pending_reg <= pending_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      phase_next   = phase_reg;
      width_next   = width_reg;
      cnt_next     = cnt_reg;
      pending_next = pending_reg;
      case (state_reg)
         IDLE: begin
            pending_next = 1'b0;
            if (active) state_next = ARMED;
         end
         ARMED: begin
            if (!active) begin
               state_next = IDLE;
            end else if (phase != phase_reg || width != width_reg) begin
               state_next = LOAD;
            end else if (pending_reg && bsync_event) begin
               state_next   = DELAY;
               cnt_next     = '0;
               pending_next = 1'b0;
            end else if (trig_edge) begin
               pending_next = 1'b1;
            end
         end
         LOAD: begin
            phase_next = phase;
            width_next = width;
            state_next = ARMED;
         end
         DELAY: begin
            if (!active) begin
               state_next   = IDLE;
               cnt_next     = '0;
               pending_next = 1'b0;
            end else if (cnt_reg == CNT_W'(phase_reg)) begin
               state_next = PULSE;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         PULSE: begin
            if (!active) begin
               state_next   = IDLE;
               cnt_next     = '0;
               pending_next = 1'b0;
            end else if (cnt_reg == CNT_W'(width_last)) begin
               state_next = ARMED;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign state    = state_reg;
   assign trig_out = (state_reg == PULSE);

`ifdef TRIGGER_ARRAY_MISSED_CNT_EN
   logic [MISSED_W-1:0] missed_reg;
   logic                missed_edge;

   // Edges landing outside IDLE/ARMED are dropped; count them, saturating.
   assign missed_edge = trig_edge & en &
                        (state_reg == LOAD || state_reg == DELAY || state_reg == PULSE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         missed_reg <= '0;
      else if (missed_edge && missed_reg != {MISSED_W{1'b1}})
         missed_reg <= missed_reg + MISSED_W'(1);
   end

   assign missed = missed_reg;
`else
`endif

endmodule

// File: rtl/trigger_array.sv
// NUM_CH trigger channels sharing one registered trigger edge detector.
// Build with TRIGGER_ARRAY_MISSED_CNT_EN to add per-channel missed-edge counters.
module trigger_array
   import trigger_array_pkg::*;
#(
   parameter int NUM_CH  = 4,
   parameter int PHASE_W = 16,
   parameter int WIDTH_W = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        trigger,
   input  logic                        bsync_event,
   input  logic                        bsync_ready,
   input  logic [NUM_CH-1:0]           ch_en,
   input  logic [NUM_CH*PHASE_W-1:0]   ch_phase,
   input  logic [NUM_CH*WIDTH_W-1:0]   ch_width,
   output logic [NUM_CH*STATE_W-1:0]   trig_state,
`ifdef TRIGGER_ARRAY_MISSED_CNT_EN
   output logic [NUM_CH-1:0]           trig_out,
   output logic [NUM_CH*MISSED_W-1:0]  trig_missed
`else
   output logic [NUM_CH-1:0]           trig_out
`endif
);

   logic trig_r_reg;
   logic trig_edge_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         trig_r_reg    <= 1'b0;
         trig_edge_reg <= 1'b0;
      end else begin
         trig_r_reg    <= trigger;
         trig_edge_reg <= trigger & ~trig_r_reg;
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
         trigger_array_channel #(
            .PHASE_W (PHASE_W),
            .WIDTH_W (WIDTH_W)
         ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .trig_edge   (trig_edge_reg),
            .bsync_event (bsync_event),
            .bsync_ready (bsync_ready),
            .en          (ch_en[gi]),
            .phase       (ch_phase[gi*PHASE_W +: PHASE_W]),
            .width       (ch_width[gi*WIDTH_W +: WIDTH_W]),
            .state       (trig_state[gi*STATE_W +: STATE_W]),
`ifdef TRIGGER_ARRAY_MISSED_CNT_EN
            .trig_out    (trig_out[gi]),
            .missed      (trig_missed[gi*MISSED_W +: MISSED_W])
`else
            .trig_out    (trig_out[gi])
`endif
         );
      end
   endgenerate

endmodule

// File: tb/tb_trigger_array.sv
// Directed self-checking bench for trigger_array (NUM_CH=4, 16-bit fields).
module tb_trigger_array;

   localparam int NUM_CH  = 4;
   localparam int PHASE_W = 16;
   localparam int WIDTH_W = 16;

   logic                        clk = 1'b0;
   logic                        rst;
   logic                        trigger;
   logic                        bsync_event;
   logic                        bsync_ready;
   logic [NUM_CH-1:0]           ch_en;
   logic [NUM_CH*PHASE_W-1:0]   ch_phase;
   logic [NUM_CH*WIDTH_W-1:0]   ch_width;
   logic [NUM_CH*3-1:0]         trig_state;
   logic [NUM_CH-1:0]           trig_out;
`ifdef TRIGGER_ARRAY_MISSED_CNT_EN
   logic [NUM_CH*8-1:0]         trig_missed;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   trigger_array #(
      .NUM_CH  (NUM_CH),
      .PHASE_W (PHASE_W),
      .WIDTH_W (WIDTH_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .trigger     (trigger),
      .bsync_event (bsync_event),
      .bsync_ready (bsync_ready),
      .ch_en       (ch_en),
      .ch_phase    (ch_phase),
      .ch_width    (ch_width),
      .trig_state  (trig_state),
`ifdef TRIGGER_ARRAY_MISSED_CNT_EN
      .trig_out    (trig_out),
      .trig_missed (trig_missed)
`else
      .trig_out    (trig_out)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [2:0] st(input int ch);
      return trig_state[ch*3 +: 3];
   endfunction

   task automatic set_cfg(input int ch, input int ph, input int wd);
      ch_phase[ch*PHASE_W +: PHASE_W] = PHASE_W'(ph);
      ch_width[ch*WIDTH_W +: WIDTH_W] = WIDTH_W'(wd);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      trigger = 1'b0;
      bsync_event = 1'b0;
      ch_en = '0;
      ch_phase = '0;
      ch_width = '0;
      tick();
      rst = 1'b0;
   endtask

   // Rising edge, then one more cycle so the channel latches pending.
   task automatic arm_edge();
      trigger = 1'b1;
      tick();
      trigger = 1'b0;
      tick();
   endtask

   task automatic fire();
      bsync_event = 1'b1;
      tick();
      bsync_event = 1'b0;
   endtask

   int first_n [NUM_CH];
   int len_n   [NUM_CH];
   int hi3;
   logic [NUM_CH-1:0] exp_out;

   initial begin
      // Reset state
      rst = 1'b1; trigger = 1'b0; bsync_event = 1'b0; bsync_ready = 1'b1;
      ch_en = '0; ch_phase = '0; ch_width = '0;
      #2;
      chk("reset_state", 32'(trig_state), 32'h0);
      chk("reset_out", 32'(trig_out), 32'h0);
      tick();
      rst = 1'b0;

      // Single channel, phase 5, width 3
      ch_en = 4'b0001;
      set_cfg(0, 5, 3);
      tick(); chk("t1_armed", 32'(st(0)), 32'd1);
      tick(); chk("t1_load", 32'(st(0)), 32'd2);
      tick(); chk("t1_rearmed", 32'(st(0)), 32'd1);
      chk("t1_ch1_idle", 32'(st(1)), 32'd0);
      arm_edge();
      fire();
      chk("t1_delay", 32'(st(0)), 32'd3);
      for (int n = 1; n <= 10; n++) begin
         tick();
         chk($sformatf("t1_out_n%0d", n), 32'(trig_out), (n >= 6 && n <= 8) ? 32'd1 : 32'd0);
      end
      chk("t1_back_armed", 32'(st(0)), 32'd1);

      // Four channels, shared edge and event
      do_reset();
      chk("t2_reset", 32'(trig_state), 32'h0);
      ch_en = 4'b1111;
      set_cfg(0, 0, 0);     first_n[0] = 1;  len_n[0] = 1;
      set_cfg(1, 1, 1);     first_n[1] = 2;  len_n[1] = 1;
      set_cfg(2, 10, 4);    first_n[2] = 11; len_n[2] = 4;
      set_cfg(3, 0, 65535); first_n[3] = 1;  len_n[3] = 65535;
      repeat (3) tick();
      chk("t2_all_armed", 32'(trig_state), 32'h249);
      arm_edge();
      fire();
      hi3 = 0;
      for (int n = 0; n <= 65600; n++) begin
         if (n > 0) tick();
         if (n <= 20) begin
            for (int c = 0; c < NUM_CH; c++)
               exp_out[c] = (n >= first_n[c] && n < first_n[c] + len_n[c]);
            chk($sformatf("t2_out_n%0d", n), 32'(trig_out), 32'(exp_out));
         end
         if (trig_out[3]) hi3++;
      end
      chk("t2_ch3_width", hi3, 32'd65535);
      chk("t2_end_states", 32'(trig_state), 32'h249);

      // Phase change during DELAY
      do_reset();
      ch_en = 4'b0001;
      set_cfg(0, 3, 2);
      repeat (3) tick();
      chk("t3_armed", 32'(st(0)), 32'd1);
      arm_edge();
      fire();
      set_cfg(0, 8, 2);
      for (int n = 1; n <= 8; n++) begin
         tick();
         chk($sformatf("t3_out_n%0d", n), 32'(trig_out), (n == 4 || n == 5) ? 32'd1 : 32'd0);
         chk($sformatf("t3_st_n%0d", n), 32'(st(0)),
             (n <= 3) ? 32'd3 : (n <= 5) ? 32'd4 : (n == 7) ? 32'd2 : 32'd1);
      end
      arm_edge();
      fire();
      for (int n = 1; n <= 12; n++) begin
         tick();
         chk($sformatf("t3b_out_n%0d", n), 32'(trig_out), (n == 9 || n == 10) ? 32'd1 : 32'd0);
      end
      chk("t3b_armed", 32'(st(0)), 32'd1);

      // Disable channel 1 mid-pulse
      do_reset();
      ch_en = 4'b0011;
      set_cfg(0, 0, 5);
      set_cfg(1, 0, 5);
      repeat (3) tick();
      arm_edge();
      fire();
      tick(); chk("t4_pulse_n1", 32'(trig_out), 32'h3);
      tick(); chk("t4_pulse_n2", 32'(trig_out), 32'h3);
      ch_en = 4'b0001;
      tick();
      chk("t4_abort_out", 32'(trig_out), 32'h1);
      chk("t4_ch1_idle", 32'(st(1)), 32'd0);
      chk("t4_ch0_pulse", 32'(st(0)), 32'd4);
      repeat (3) tick();
      chk("t4_ch0_done", 32'(st(0)), 32'd1);
      chk("t4_out_low", 32'(trig_out), 32'h0);
      ch_en = 4'b0011;
      tick();
      fire();
      chk("t4_no_stale_pending", 32'(trig_state), 32'h009);
      chk("t4_no_pulse", 32'(trig_out), 32'h0);

      // Asynchronous reset mid-pulse / mid-delay
      do_reset();
      ch_en = 4'b0011;
      set_cfg(0, 0, 8);
      set_cfg(1, 10, 1);
      repeat (3) tick();
      arm_edge();
      fire();
      tick(); tick();
      chk("t5_pre_out", 32'(trig_out), 32'h1);
      chk("t5_pre_ch1", 32'(st(1)), 32'd3);
      #2 rst = 1'b1;
      #2;
      chk("t5_async_out", 32'(trig_out), 32'h0);
      chk("t5_async_state", 32'(trig_state), 32'h0);
      tick();
      rst = 1'b0;

`ifdef TRIGGER_ARRAY_MISSED_CNT_EN
      // Saturating missed-edge counter
      do_reset();
      ch_en = 4'b0001;
      set_cfg(0, 0, 2000);
      repeat (3) tick();
      arm_edge();
      fire();
      tick();
      for (int k = 0; k < 300; k++) begin
         trigger = 1'b1; tick();
         trigger = 1'b0; tick();
      end
      chk("t6_missed_sat", 32'(trig_missed[7:0]), 32'd255);
      chk("t6_missed_ch1", 32'(trig_missed[15:8]), 32'd0);
      chk("t6_still_pulse", 32'(st(0)), 32'd4);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
